wbm_sdram_exerciser: RTL and testbench

Wishbone classic master that drives the SDRAM controller's Wishbone slave port. It is the initiator side of that port.
On a start pulse it writes a pseudo-random pattern to a contiguous word range, reads the range back, compares each word and reports pass/fail, error count and first failing address.
It is used as the on-chip traffic generator and self-test for the SDRAM subsystem.

---
 rtl/wbm_pkg.sv | 27 ++
 rtl/wbm_lfsr32.sv | 34 +++
 rtl/wbm_sdram_exerciser.sv | 258 +++++++++++++++++++++++++
 tb/tb_wbm_sdram_exerciser.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// Shared types, constants and LFSR helpers for the Wishbone SDRAM exerciser.
package wbm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WR_GAP = 3'd2,
    RD     = 3'd3,
    RD_GAP = 3'd4,
    FIN    = 3'd5
  } state_e;

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;
  localparam logic [3:0]  SEL_ALL    = 4'hF;

  // One Galois step, shifting right.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? LFSR_RESET : s;
  endfunction

endpackage

// File: rtl/wbm_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step; shared by write and read phases.
module wbm_lfsr32
  import wbm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] seed_i,
  output logic [31:0] q_o
);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = seed_fix(seed_i);
    end else if (step_i) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= LFSR_RESET;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/wbm_sdram_exerciser.sv
// Wishbone classic master: writes an LFSR pattern over a word range, reads it back
// and reports pass/fail, mismatch count and first failing address.
module wbm_sdram_exerciser
  import wbm_pkg::*;
#(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned GAP       = 1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = 4;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d, cnt_q, cnt_d, err_q, err_d;
  logic [ADDR_W-1:0] base_q, base_d, adr_q, adr_d, ferr_q, ferr_d;
  logic [31:0]       seed_q, seed_d, dat_q, dat_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;

  logic              lfsr_load, lfsr_step;
  logic [31:0]       lfsr_seed, lfsr_q, lfsr_d;
  logic              ack_ok, last, launch_wr, launch_rd, abort;
  logic [CNT_W-1:0]  idx_inc;

  wbm_lfsr32 u_lfsr (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .seed_i (lfsr_seed),
    .q_o    (lfsr_q)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    seed_d    = seed_q;
    adr_d     = adr_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    lfsr_seed = seed_q;
    launch_wr = 1'b0;
    launch_rd = 1'b0;
    abort     = 1'b0;
    ack_ok    = stb_q && wbm_ack_i;
    idx_inc   = idx_q + CNT_W'(1);
    last      = (idx_inc == cnt_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = word_count;
          base_d    = base_addr;
          seed_d    = seed_fix(seed);
          err_d     = '0;
          ferr_d    = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
          idx_d     = '0;
          adr_d     = base_addr;
          if (word_count != '0) begin
            lfsr_load = 1'b1;
            lfsr_seed = seed;
            launch_wr = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      WR: begin
        if (ack_ok) begin
          lfsr_step = 1'b1;
          idx_d     = idx_inc;
          adr_d     = adr_q + ADDR_W'(ADDR_STEP);
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          gap_d     = '0;
          if (last) begin
            // Read phase replays the same pattern from the seed.
            idx_d     = '0;
            adr_d     = base_q;
            lfsr_load = 1'b1;
            if (GAP == 0) launch_rd = 1'b1;
            else          state_d   = RD_GAP;
          end else if (GAP == 0) begin
            launch_wr = 1'b1;
          end else begin
            state_d = WR_GAP;
          end
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WR_GAP: begin
        if (gap_q == GAP_LAST) launch_wr = 1'b1;
        else                   gap_d     = gap_q + GAP_W'(1);
      end
      RD: begin
        if (ack_ok) begin
          lfsr_step = 1'b1;
          if (wbm_dat_i != lfsr_q) begin
            if (err_q != '1) err_d  = err_q + CNT_W'(1);
            if (err_q == '0) ferr_d = adr_q;
          end
          idx_d = idx_inc;
          adr_d = adr_q + ADDR_W'(ADDR_STEP);
          cyc_d = 1'b0;
          stb_d = 1'b0;
          gap_d = '0;
          if (last)          state_d   = FIN;
          else if (GAP == 0) launch_rd = 1'b1;
          else               state_d   = RD_GAP;
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RD_GAP: begin
        if (gap_q == GAP_LAST) launch_rd = 1'b1;
        else                   gap_d     = gap_q + GAP_W'(1);
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Each transaction raises stb afresh and restarts the ack timeout.
    if (launch_wr || launch_rd) begin
      state_d = launch_wr ? WR : RD;
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = launch_wr;
      tmo_d   = '0;
      busy_d  = 1'b1;
    end

    if (abort) begin
      cyc_d     = 1'b0;
      stb_d     = 1'b0;
      we_d      = 1'b0;
      timeout_d = 1'b1;
      state_d   = FIN;
    end

    if (state_d == FIN) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      pass_d = (err_d == '0) && !timeout_d;
    end

    lfsr_d = lfsr_load ? seed_fix(lfsr_seed) : (lfsr_step ? lfsr_next(lfsr_q) : lfsr_q);
    dat_d  = (stb_d && we_d) ? lfsr_d : 32'h0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      seed_q    <= LFSR_RESET;
      adr_q     <= '0;
      gap_q     <= '0;
      tmo_q     <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      ferr_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      adr_q     <= adr_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      dat_q     <= dat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign wbm_cyc_o      = cyc_q;
  assign wbm_stb_o      = stb_q;
  assign wbm_we_o       = we_q;
  assign wbm_sel_o      = SEL_ALL;
  assign wbm_adr_o      = 32'(adr_q);
  assign wbm_dat_o      = dat_q;

endmodule

// File: tb/tb_wbm_sdram_exerciser.sv
// Self-checking bench: table vectors, random runs against a word-level model,
// plus hand sequences for ack timeout and reset during the read phase.
module tb_wbm_sdram_exerciser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [22:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [22:0] first_err_addr;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] rdat = '0;

  always #5 clk = ~clk;

  wbm_sdram_exerciser #(.TIMEOUT(16)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .wbm_cyc_o      (cyc),
    .wbm_stb_o      (stb),
    .wbm_we_o       (we),
    .wbm_sel_o      (sel),
    .wbm_adr_o      (adr),
    .wbm_dat_o      (wdat),
    .wbm_dat_i      (rdat),
    .wbm_ack_i      (ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit ack_hi = 1'b0;
  bit stall_en = 1'b0;
  int stall_idx = 0;
  int wr_cnt = 0;
  int wr_base = 0;
  int done_cnt = 0;
  int run_len = 0;
  int last_run = 0;

  logic [31:0] mem [int unsigned];
  bit          bad [int unsigned];
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  logic [31:0] rd_adr_q[$];

  // Slave: ideal single-cycle ack, optional stall on one write, optional ack stuck high.
  assign ack = ack_hi | (cyc & stb & ~(stall_en & we & ((wr_cnt - wr_base) == stall_idx)));

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] v;
    v = mem.exists(a) ? mem[a] : 32'h0;
    if (bad.exists(a)) v = v ^ 32'h1;
    return v;
  endfunction

  always @(negedge clk) rdat <= rd_word(adr);

  always @(posedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (done) done_cnt = done_cnt + 1;
      if (cyc && stb && !ack) run_len = run_len + 1;
      else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (cyc && stb && ack) begin
        if (we) begin
          mem[adr] = wdat;
          wr_adr_q.push_back(adr);
          wr_dat_q.push_back(wdat);
          wr_cnt <= wr_cnt + 1;
        end else begin
          rd_adr_q.push_back(adr);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  task automatic check_idle(input string nm);
    chk({nm, " cyc"},  32'(cyc), 32'h0);
    chk({nm, " stb"},  32'(stb), 32'h0);
    chk({nm, " we"},   32'(we), 32'h0);
    chk({nm, " sel"},  32'(sel), 32'hF);
    chk({nm, " adr"},  adr, 32'h0);
    chk({nm, " dat"},  wdat, 32'h0);
    chk({nm, " busy"}, 32'(busy), 32'h0);
    chk({nm, " done"}, 32'(done), 32'h0);
    chk({nm, " pass"}, 32'(pass), 32'h0);
    chk({nm, " tmo"},  32'(timeout), 32'h0);
    chk({nm, " err"},  32'(err_count), 32'h0);
    chk({nm, " ferr"}, 32'(first_err_addr), 32'h0);
  endtask

  task automatic run_case(input string nm, input logic [22:0] b, input logic [15:0] n,
                          input logic [31:0] s, input bit exp_pass, input logic [15:0] exp_err,
                          input logic [22:0] exp_ferr);
    logic [31:0] x;
    logic [22:0] a;
    int k;
    wr_adr_q.delete();
    wr_dat_q.delete();
    rd_adr_q.delete();
    mem.delete();
    wr_base = wr_cnt;
    @(negedge clk);
    base_addr = b; word_count = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy_after_start"}, 32'(busy), 32'(n != 0));
    k = 0;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " done_seen"}, 32'(done), 32'h1);
    chk({nm, " pass"}, 32'(pass), 32'(exp_pass));
    chk({nm, " err_count"}, 32'(err_count), 32'(exp_err));
    chk({nm, " first_err_addr"}, 32'(first_err_addr), 32'(exp_ferr));
    chk({nm, " timeout"}, 32'(timeout), 32'h0);
    chk({nm, " busy_at_done"}, 32'(busy), 32'h0);
    @(negedge clk);
    chk({nm, " done_one_cycle"}, 32'(done), 32'h0);
    chk({nm, " pass_held"}, 32'(pass), 32'(exp_pass));
    chk({nm, " n_writes"}, 32'(wr_adr_q.size()), 32'(n));
    chk({nm, " n_reads"}, 32'(rd_adr_q.size()), 32'(n));
    x = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 23'(i * 4);
      if (i < wr_adr_q.size()) begin
        chk($sformatf("%s wr_adr[%0d]", nm, i), wr_adr_q[i], 32'(a));
        chk($sformatf("%s wr_dat[%0d]", nm, i), wr_dat_q[i], x);
      end
      if (i < rd_adr_q.size()) chk($sformatf("%s rd_adr[%0d]", nm, i), rd_adr_q[i], 32'(a));
      x = ref_step(x);
    end
  endtask

  typedef struct {
    logic [22:0] base;
    logic [15:0] cnt;
    logic [31:0] seed;
    bit          bad_en;
    logic [22:0] bad;
    bit          exp_pass;
    logic [15:0] exp_err;
    logic [22:0] exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int dbase;
    vecs[0] = '{base: 23'h000100, cnt: 16'd8, seed: 32'h1,         bad_en: 1'b0, bad: 23'h0,
                exp_pass: 1'b1, exp_err: 16'd0, exp_ferr: 23'h0};
    vecs[1] = '{base: 23'h000100, cnt: 16'd8, seed: 32'h1,         bad_en: 1'b1, bad: 23'h108,
                exp_pass: 1'b0, exp_err: 16'd1, exp_ferr: 23'h108};
    vecs[2] = '{base: 23'h000040, cnt: 16'd0, seed: 32'h5,         bad_en: 1'b0, bad: 23'h0,
                exp_pass: 1'b1, exp_err: 16'd0, exp_ferr: 23'h0};
    vecs[3] = '{base: 23'h7FFFF8, cnt: 16'd4, seed: 32'hDEADBEEF,  bad_en: 1'b0, bad: 23'h0,
                exp_pass: 1'b1, exp_err: 16'd0, exp_ferr: 23'h0};
    vecs[4] = '{base: 23'h000800, cnt: 16'd5, seed: 32'h0,         bad_en: 1'b1, bad: 23'h80C,
                exp_pass: 1'b0, exp_err: 16'd1, exp_ferr: 23'h80C};

    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      bad.delete();
      if (vecs[i].bad_en) bad[32'(vecs[i].bad)] = 1'b1;
      run_case($sformatf("vec%0d", i), vecs[i].base, vecs[i].cnt, vecs[i].seed,
               vecs[i].exp_pass, vecs[i].exp_err, vecs[i].exp_ferr);
    end
    bad.delete();

    // Write index 3 never acked: abort after 16 cycles of stb.
    stall_en = 1'b1; stall_idx = 3;
    mem.delete(); wr_adr_q.delete(); rd_adr_q.delete();
    wr_base = wr_cnt; dbase = done_cnt;
    @(negedge clk);
    base_addr = 23'h0; word_count = 16'd8; seed = 32'hACE1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("tmo done_seen", 32'(done), 32'h1);
    chk("tmo timeout", 32'(timeout), 32'h1);
    chk("tmo pass", 32'(pass), 32'h0);
    chk("tmo err_count", 32'(err_count), 32'h0);
    chk("tmo cyc_dropped", 32'(cyc), 32'h0);
    @(negedge clk);
    chk("tmo done_one_cycle", 32'(done), 32'h0);
    chk("tmo stb_high_cycles", 32'(last_run), 32'd16);
    chk("tmo writes_before_stall", 32'(wr_adr_q.size()), 32'd3);
    chk("tmo no_reads", 32'(rd_adr_q.size()), 32'd0);
    chk("tmo timeout_sticky", 32'(timeout), 32'h1);
    chk("tmo one_done", 32'(done_cnt - dbase), 32'd1);
    stall_en = 1'b0;

    for (int r = 0; r < 6; r++) begin
      logic [22:0] b, a, f;
      logic [15:0] n;
      logic [31:0] s;
      int e;
      b = 23'($urandom) & ~23'h3;
      n = 16'($urandom_range(12, 1));
      s = $urandom;
      bad.delete();
      e = 0; f = '0;
      for (int i = 0; i < int'(n); i++) begin
        if ($urandom_range(3, 0) == 0) begin
          a = b + 23'(i * 4);
          bad[32'(a)] = 1'b1;
          if (e == 0) f = a;
          e++;
        end
      end
      run_case($sformatf("rnd%0d", r), b, n, s, e == 0, 16'(e), f);
    end
    bad.delete();

    // Ack stuck high while stb is low, reset during the read phase.
    ack_hi = 1'b1;
    mem.delete();
    repeat (3) @(negedge clk);
    chk("ackhi idle_no_cyc", 32'(cyc), 32'h0);
    @(negedge clk);
    base_addr = 23'h200; word_count = 16'd8; seed = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dbase = done_cnt;
    k = 0;
    while (!(cyc && !we) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid reached_read", 32'(cyc && !we), 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid cyc_drop", 32'(cyc), 32'h0);
    chk("rstmid stb_drop", 32'(stb), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_idle("rstmid");
    chk("rstmid no_done", 32'(done_cnt - dbase), 32'd0);
    run_case("post_rst", 23'h300, 16'd6, 32'h1234_5678, 1'b1, 16'd0, 23'h0);
    ack_hi = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
